imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Byte-stream program loader: writer side of the instruction memory that the core reads by word
//  address. Receives a framed image over a valid/ready byte stream and assembles little-endian
//  32-bit words. Writes them sequentially into the instruction memory write port.
//  Holds the core in reset until a frame loads with a correct checksum.
// PARAMETERS
//  ADDR_W      10      instruction memory word-address width (1024 words)
//  SYNC_BYTE   8'hA5   frame start marker
//  TIMEOUT_CYC 100000  inter-byte timeout in clk cycles (used only with IMEM_LOADER_TIMEOUT_EN)
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  rst         in   1       asynchronous, active-low reset
//  in_valid    in   1       byte stream valid
//  in_data     in   8       byte stream data
//  in_ready    out  1       loader accepts byte; transfer = in_valid & in_ready
//  imem_we     out  1       instruction memory write strobe, one-cycle pulse per word
//  imem_addr   out  ADDR_W  word address (byte address >> 2)
//  imem_wdata  out  32      word to write
//  core_hold   out  1       1 = core and its PC held in reset
//  busy        out  1       frame in progress (state not IDLE/DONE/ERROR)
//  done        out  1       last frame loaded and checksum matched
//  err         out  1       last frame failed (length, checksum or timeout)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; in_ready=1; imem_we=0; imem_addr=0; imem_wdata=0;
//   core_hold=1; busy=0; done=0; err=0; byte index, word count, checksum cleared.
//  Frame: SYNC_BYTE, LEN_LO, LEN_HI (LEN = word count), LEN*4 data bytes (LSB first), CSUM.
//   CSUM = XOR of all data bytes only; LEN=0 -> CSUM must be 8'h00.
//  FSM: IDLE -SYNC-> LEN0 -> LEN1 -> DATA (LEN>0) or CSUM (LEN=0); DATA -last byte-> CSUM;
//   CSUM -match-> DONE, -mismatch-> ERROR. Non-SYNC bytes in IDLE/DONE/ERROR are dropped.
//  LEN > 2**ADDR_W: ERROR on the LEN1 byte; no writes issued.
//  Entering LEN0 from any state: done=0, err=0, core_hold=1, word address reset to 0.
//  in_ready is 1 in every state; loader never stalls the stream.
//  Word assembly: byte k of a word goes to bits [8k+7:8k]. The cycle after the 4th byte is
//   accepted: imem_we=1 for exactly one cycle; imem_addr=word index; imem_wdata=assembled word.
//   Word index increments after each write; no wrap (bounded by length check).
//  Latency: core_hold falls and done rises in the cycle after the matching CSUM byte is accepted.
//  ERROR: err=1, core_hold stays 1, memory contents undefined; leave ERROR only via new SYNC.
//  DONE: core_hold=0, done=1; a SYNC byte restarts loading and re-asserts core_hold immediately.
//  Reset mid-frame: frame abandoned; FSM returns to IDLE with core_hold=1.
// CONFIGURATION
//  IMEM_LOADER_TIMEOUT_EN defined:
//   - Counter clears on every accepted byte. In LEN0/LEN1/DATA/CSUM, TIMEOUT_CYC cycles with no
//     accepted byte -> ERROR (err=1).
//   - Counter is idle in IDLE/DONE/ERROR.
//  IMEM_LOADER_TIMEOUT_EN not defined:
//   - No counter; a frame waits indefinitely for its next byte.
//   - TIMEOUT_CYC is ignored.
// TESTING
//  1. Reset -> core_hold=1, done=0, err=0, imem_we=0, in_ready=1.
//  2. Send A5 02 00 | 13 00 00 00 | 6F 00 00 00 | 7C
//     -> writes 0x00000013 @0, then 0x0000006F @1; done=1, core_hold=0 next cycle.
//  3. Same frame with CSUM 7D -> both words written, err=1, done=0, core_hold=1.
//  4. A5 01 04 (LEN=1025) -> err=1 on LEN_HI, no imem_we pulse; then A5 00 00 00 -> done=1.
//  5. Drop rst low after 2 data bytes -> IDLE, core_hold=1, no write.
//     Junk byte 0x11 in IDLE -> ignored.
//  6. TIMEOUT_EN, TIMEOUT_CYC=16: A5 01 00 13, then 16 idle cycles -> err=1, core_hold=1.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles framed little-endian words into instruction memory
// and holds the core in reset until a frame with a good checksum lands. Define
// IMEM_LOADER_TIMEOUT_EN to abort a frame after TIMEOUT_CYC cycles without an accepted byte.
module imem_loader #(
  parameter int unsigned ADDR_W      = 10,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned LEN_W     = 16;
  localparam int unsigned MAX_WORDS = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  if (TIMEOUT_CYC == 0) begin : g_timeout_chk
    $error("imem_loader: TIMEOUT_CYC must be nonzero");
  end

  state_t             state_q, state_d;
  logic [7:0]         len_lo_q, len_lo_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [23:0]        word_q, word_d;
  logic [7:0]         csum_q, csum_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic               we_d, hold_d, busy_d, done_d, err_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [31:0]        wdata_d;
  logic               accept;
  logic               timeout_c;

  assign accept = in_valid & in_ready;

`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            in_frame;

  assign in_frame = state_q inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};

  // Idle-cycle counter; only runs while a frame is open
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q <= '0;
    end else if (accept || !in_frame) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  assign timeout_c = in_frame && !accept && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_lo_q   <= '0;
      len_q      <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      word_cnt_q <= '0;
      in_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_hold  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      word_cnt_q <= word_cnt_d;
      in_ready   <= 1'b1;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      core_hold  <= hold_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  // Frame parser: next state and next register values
  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    csum_d     = csum_q;
    word_cnt_d = word_cnt_q;
    we_d       = 1'b0;
    addr_d     = imem_addr;
    wdata_d    = imem_wdata;
    hold_d     = core_hold;
    done_d     = done;
    err_d      = err;

    if (accept) begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (in_data == SYNC_BYTE) begin
            state_d    = S_LEN0;
            done_d     = 1'b0;
            err_d      = 1'b0;
            hold_d     = 1'b1;
            word_cnt_d = '0;
            addr_d     = '0;
            byte_idx_d = '0;
            csum_d     = '0;
          end
        end
        S_LEN0: begin
          len_lo_d = in_data;
          state_d  = S_LEN1;
        end
        S_LEN1: begin
          len_d = {in_data, len_lo_q};
          if (32'(len_d) > MAX_WORDS) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else if (len_d == '0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          csum_d     = csum_q ^ in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_d[7:0]   = in_data;
            2'd1: word_d[15:8]  = in_data;
            2'd2: word_d[23:16] = in_data;
            default: begin
              we_d       = 1'b1;
              addr_d     = ADDR_W'(word_cnt_q);
              wdata_d    = {in_data, word_q};
              word_cnt_d = word_cnt_q + CNT_W'(1);
              if (32'(word_cnt_q) + 32'd1 == 32'(len_q)) begin
                state_d = S_CSUM;
              end
            end
          endcase
        end
        S_CSUM: begin
          if (in_data == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (timeout_c) begin
      state_d = S_ERROR;
      err_d   = 1'b1;
    end

    busy_d = state_d inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are built from random words, expected writes are
// queued at build time and a monitor pops them on every imem_we pulse.
module tb_imem_loader;

  localparam int unsigned ADDR_W    = 10;
  localparam int          MAX_WORDS = 1 << ADDR_W;
  localparam logic [7:0]  SYNC      = 8'hA5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;
  typedef logic [7:0] byte_q_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              busy;
  logic              done;
  logic              err;

  int  checks   = 0;
  int  failures = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_W(ADDR_W),
    .SYNC_BYTE(SYNC),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .core_hold(core_hold),
    .busy(busy),
    .done(done),
    .err(err)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (rst && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0d data=0x%08h required=no write", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check32("write_addr", 32'(imem_addr), 32'(e.addr));
        check32("write_data", imem_wdata, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input byte_q_t f, input bit gaps);
    for (int i = 0; i < f.size(); i++) begin
      send_byte(f[i], (gaps && i != f.size() - 1) ? int'($urandom_range(0, 2)) : 0);
    end
  endtask

  task automatic check_status(input string tag, input logic exp_done, input logic exp_err);
    check_bit({tag, "_done"}, done, exp_done);
    check_bit({tag, "_err"}, err, exp_err);
    check_bit({tag, "_core_hold"}, core_hold, !exp_done);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  // Reference model: build a frame from random words and queue the writes it must cause
  task automatic gen_frame(input int len, input bit bad, output byte_q_t f, output bit exp_done);
    logic [7:0]  x;
    logic [7:0]  cs;
    logic [31:0] w;
    x = 8'h00;
    f = {};
    f.push_back(SYNC);
    f.push_back(8'(len));
    f.push_back(8'(len >> 8));
    if (len > MAX_WORDS) begin
      exp_done = 1'b0;
      return;
    end
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      exp_q.push_back('{addr: ADDR_W'(i), data: w});
      for (int k = 0; k < 4; k++) begin
        f.push_back(8'(w >> (8 * k)));
        x = x ^ 8'(w >> (8 * k));
      end
    end
    cs = bad ? (x ^ 8'($urandom_range(1, 255))) : x;
    f.push_back(cs);
    exp_done = !bad;
  endtask

  task automatic junk_byte();
    logic [7:0] j;
    j = 8'($urandom);
    if (j == SYNC) j = 8'h11;
    send_byte(j, int'($urandom_range(0, 1)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog elapsed required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t f;
    bit      ed;

    repeat (2) @(posedge clk);
    #1;
    check_bit("reset_core_hold", core_hold, 1'b1);
    check_bit("reset_done", done, 1'b0);
    check_bit("reset_err", err, 1'b0);
    check_bit("reset_imem_we", imem_we, 1'b0);
    check_bit("reset_in_ready", in_ready, 1'b1);
    check_bit("reset_busy", busy, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Two-word directed frame, good checksum
    f = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
    exp_q.push_back('{addr: ADDR_W'(0), data: 32'h0000_0013});
    exp_q.push_back('{addr: ADDR_W'(1), data: 32'h0000_006F});
    send_frame(f, 1'b0);
    check_status("good_frame", 1'b1, 1'b0);

    // Same frame with a corrupted checksum: words still written
    f = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7D};
    exp_q.push_back('{addr: ADDR_W'(0), data: 32'h0000_0013});
    exp_q.push_back('{addr: ADDR_W'(1), data: 32'h0000_006F});
    send_frame(f, 1'b1);
    check_status("bad_csum", 1'b0, 1'b1);

    // Oversized length rejected on LEN_HI, then an empty frame
    f = {8'hA5, 8'h01, 8'h04};
    send_frame(f, 1'b0);
    check_status("len_1025", 1'b0, 1'b1);
    f = {8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(f, 1'b0);
    check_status("len_0", 1'b1, 1'b0);
    send_byte(8'h11, 0);
    check_status("junk_in_done", 1'b1, 1'b0);

    // Reset in the middle of a frame
    f = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
    send_frame(f, 1'b0);
    check_bit("midframe_busy", busy, 1'b1);
    check_bit("midframe_core_hold", core_hold, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_bit("rst_mid_core_hold", core_hold, 1'b1);
    check_bit("rst_mid_busy", busy, 1'b0);
    check_bit("rst_mid_done", done, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    send_byte(8'h11, 0);
    check_status("junk_in_idle", 1'b0, 1'b0);

    // Largest legal image, back to back
    gen_frame(MAX_WORDS, 1'b0, f, ed);
    send_frame(f, 1'b0);
    check_status("len_max", ed, !ed);

    // Empty frame with wrong checksum
    gen_frame(0, 1'b1, f, ed);
    send_frame(f, 1'b1);
    check_status("len_0_bad", 1'b0, 1'b1);

    // Randomized frames with gaps and junk between them
    for (int n = 0; n < 10; n++) begin
      gen_frame(int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0), f, ed);
      send_frame(f, 1'b1);
      check_status("rand_frame", ed, !ed);
      junk_byte();
      check_status("rand_junk", ed, !ed);
    end

`ifdef IMEM_LOADER_TIMEOUT_EN
    f = {8'hA5, 8'h01, 8'h00, 8'h13};
    send_frame(f, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    check_bit("timeout_early_err", err, 1'b0);
    check_bit("timeout_early_busy", busy, 1'b1);
    @(posedge clk);
    #1;
    check_status("timeout", 1'b0, 1'b1);
`endif

    repeat (5) @(posedge clk);
    #1;
    check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
